// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN car-motion scheduler. It latches floor calls, chooses the
// travel direction, times floor-to-floor travel and the door dwell, and drives the car
// position, motion and door outputs.
// Optional feature: define ELEVATOR_ESTOP_EN to add the emergency-stop HALT state.
// In the HALT state the FSM freezes and later resumes the interrupted state.
module elevator_scheduler #(
    parameter int NUM_FLOORS    = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  estop,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  halted
);

    localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic               DIR_UP      = 1'b1;
    localparam logic               DIR_DOWN    = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR
`ifdef ELEVATOR_ESTOP_EN
        , S_HALT
`endif
    } state_t;

    state_t                  state, state_n;
    logic                    dir, dir_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [FLOOR_W-1:0]      floor_n;
    logic [NUM_FLOORS-1:0]   pending_n;
    logic [NUM_FLOORS-1:0]   req;
    logic [NUM_FLOORS-1:0]   cur_oh, up_oh, dn_oh;
    logic [NUM_FLOORS-1:0]   above, below, above_up, below_dn;
    logic [FLOOR_W-1:0]      up_floor, dn_floor;
`ifdef ELEVATOR_ESTOP_EN
    state_t                  saved, saved_n;
`else
    logic                    estop_unused;
    assign estop_unused = estop;
`endif

    assign req      = pending | call_req;
    assign up_floor = cur_floor + FLOOR_W'(1);
    assign dn_floor = cur_floor - FLOOR_W'(1);
    assign cur_oh   = NUM_FLOORS'(1) << cur_floor;
    assign up_oh    = NUM_FLOORS'(1) << up_floor;
    assign dn_oh    = NUM_FLOORS'(1) << dn_floor;

    // Floor masks relative to the current floor and to the floor about to be reached
    always_comb begin
        above    = '0;
        below    = '0;
        above_up = '0;
        below_dn = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            above[i]    = i > 32'(cur_floor);
            below[i]    = i < 32'(cur_floor);
            above_up[i] = i > 32'(cur_floor) + 32'd1;
            below_dn[i] = i + 32'd1 < 32'(cur_floor);
        end
    end

    // Next-state, floor, direction, counter and call-latch logic
    always_comb begin
        state_n   = state;
        floor_n   = cur_floor;
        dir_n     = dir;
        cnt_n     = cnt;
        pending_n = pending | call_req;
`ifdef ELEVATOR_ESTOP_EN
        saved_n   = saved;
`endif
        case (state)
            S_IDLE: begin
                if (req[cur_floor]) begin
                    state_n   = S_DOOR;
                    cnt_n     = DOOR_LOAD;
                    pending_n = req & ~cur_oh;
                end else if (dir == DIR_UP && |(req & above)) begin
                    state_n = S_UP;
                    cnt_n   = TRAVEL_LOAD;
                end else if (dir == DIR_DOWN && |(req & below)) begin
                    state_n = S_DOWN;
                    cnt_n   = TRAVEL_LOAD;
                end else if (|(req & above)) begin
                    dir_n   = DIR_UP;
                    state_n = S_UP;
                    cnt_n   = TRAVEL_LOAD;
                end else if (|(req & below)) begin
                    dir_n   = DIR_DOWN;
                    state_n = S_DOWN;
                    cnt_n   = TRAVEL_LOAD;
                end
            end
            S_UP: begin
                if (cur_floor == TOP_FLOOR) begin
                    state_n = S_IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    floor_n = up_floor;
                    if (req[up_floor]) begin
                        state_n   = S_DOOR;
                        cnt_n     = DOOR_LOAD;
                        pending_n = req & ~up_oh;
                    end else if (|(req & above_up)) begin
                        cnt_n = TRAVEL_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DOWN: begin
                if (cur_floor == '0) begin
                    state_n = S_IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    floor_n = dn_floor;
                    if (req[dn_floor]) begin
                        state_n   = S_DOOR;
                        cnt_n     = DOOR_LOAD;
                        pending_n = req & ~dn_oh;
                    end else if (|(req & below_dn)) begin
                        cnt_n = TRAVEL_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DOOR: begin
                // A call for the open floor extends the dwell instead of being latched
                pending_n = pending | (call_req & ~cur_oh);
                if (call_req[cur_floor]) begin
                    cnt_n = DOOR_LOAD;
                end else if (cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
`ifdef ELEVATOR_ESTOP_EN
            S_HALT: begin
                if (!estop) begin
                    state_n = saved;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase
`ifdef ELEVATOR_ESTOP_EN
        // Stop overrides every transition; everything but the call latch is frozen
        if (estop && state != S_HALT) begin
            state_n   = S_HALT;
            saved_n   = state;
            floor_n   = cur_floor;
            dir_n     = dir;
            cnt_n     = cnt;
            pending_n = pending | call_req;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cur_floor <= '0;
            dir       <= DIR_UP;
            cnt       <= '0;
            pending   <= '0;
`ifdef ELEVATOR_ESTOP_EN
            saved     <= S_IDLE;
`endif
        end else begin
            state     <= state_n;
            cur_floor <= floor_n;
            dir       <= dir_n;
            cnt       <= cnt_n;
            pending   <= pending_n;
`ifdef ELEVATOR_ESTOP_EN
            saved     <= saved_n;
`endif
        end
    end

    assign moving_up   = (state == S_UP);
    assign moving_down = (state == S_DOWN);
    assign door_open   = (state == S_DOOR);
`ifdef ELEVATOR_ESTOP_EN
    assign halted      = (state == S_HALT);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: scoreboard bench for elevator_scheduler (4 floors, 8/16 cycles).
module tb_elevator_scheduler;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [3:0] call_req;
    logic       estop;
    logic [1:0] cur_floor;
    logic       moving_up;
    logic       moving_down;
    logic       door_open;
    logic [3:0] pending;
    logic       halted;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];

    elevator_scheduler #(
        .NUM_FLOORS(4),
        .FLOOR_W(2),
        .TRAVEL_CYCLES(8),
        .DOOR_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .call_req(call_req),
        .estop(estop),
        .cur_floor(cur_floor),
        .moving_up(moving_up),
        .moving_down(moving_down),
        .door_open(door_open),
        .pending(pending),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedge counter used to timestamp output changes
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int f, input bit up, input bit dn,
                                       input bit door, input bit h);
        logic [1:0] fl;
        fl = f[1:0];
        return {26'b0, h, door, dn, up, fl};
    endfunction

    task automatic exp_ev(input int c, input int f, input bit up, input bit dn,
                          input bit door, input bit h);
        ev_t e;
        e.cyc = c;
        e.val = pk(f, up, dn, door, h);
        exp_q.push_back(e);
    endtask

    // Each change of the output tuple pops one expected event and checks time and value
    task automatic monitor();
        logic [31:0] val;
        logic [31:0] prev;
        ev_t         e;
        prev = '0;
        forever begin
            @(negedge clk);
            val = pk(int'(cur_floor), moving_up, moving_down, door_open, halted);
            if (mon_en) begin
                check("dir_exclusive", 32'(moving_up & moving_down), 32'd0);
                if (val != prev) begin
                    if (exp_q.size() == 0) begin
                        check("extra_event", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_cycle", e.cyc == 0 ? 32'd0 : 32'(cyc), 32'(e.cyc));
                        check("event_state", val, e.val);
                    end
                end
            end
            prev = val;
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        call_req = m;
        @(negedge clk);
        call_req = '0;
    endtask

    // Asynchronous reset: outputs are checked before any clock edge follows
    task automatic do_reset();
        mon_en = 1'b0;
        call_req = '0;
        estop = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_floor", 32'(cur_floor), 32'd0);
        check("rst_up", 32'(moving_up), 32'd0);
        check("rst_down", 32'(moving_down), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    initial begin
        int s;
        int t;
        reset = 1'b0;
        call_req = '0;
        estop = 1'b0;
        fork
            monitor();
        join_none

        // 1: call at the idle floor opens the door for 16 cycles
        do_reset();
        s = cyc + 1;
        exp_ev(s, 0, 0, 0, 1, 0);
        exp_ev(s + 16, 0, 0, 0, 0, 0);
        pulse(4'b0001);
        check("t1_pending", 32'(pending), 32'd0);
        wait_drain(60);

        // 2: run 0 -> 3, one floor every 8 cycles, door at the top
        do_reset();
        s = cyc + 1;
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 8, 1, 1, 0, 0, 0);
        exp_ev(s + 16, 2, 1, 0, 0, 0);
        exp_ev(s + 24, 3, 0, 0, 1, 0);
        exp_ev(s + 40, 3, 0, 0, 0, 0);
        pulse(4'b1000);
        check("t2_pending_set", 32'(pending), 32'h8);
        wait_until(s + 24);
        check("t2_pending_clr", 32'(pending), 32'd0);
        wait_drain(80);

        // 3: call for floor 1 during the first hop stops the car there first
        do_reset();
        s = cyc + 1;
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 8, 1, 0, 0, 1, 0);
        exp_ev(s + 24, 1, 0, 0, 0, 0);
        exp_ev(s + 25, 1, 1, 0, 0, 0);
        exp_ev(s + 33, 2, 1, 0, 0, 0);
        exp_ev(s + 41, 3, 0, 0, 1, 0);
        exp_ev(s + 57, 3, 0, 0, 0, 0);
        pulse(4'b1000);
        wait_until(s + 2);
        pulse(4'b0010);
        check("t3_pending_both", 32'(pending), 32'hA);
        wait_drain(100);

        // 4: park at floor 2, then calls at 0 and 3: serve 3, reverse, serve 0
        do_reset();
        s = cyc + 1;
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 8, 1, 1, 0, 0, 0);
        exp_ev(s + 16, 2, 0, 0, 1, 0);
        exp_ev(s + 32, 2, 0, 0, 0, 0);
        pulse(4'b0100);
        wait_drain(80);
        t = cyc + 1;
        exp_ev(t, 2, 1, 0, 0, 0);
        exp_ev(t + 8, 3, 0, 0, 1, 0);
        exp_ev(t + 24, 3, 0, 0, 0, 0);
        exp_ev(t + 25, 3, 0, 1, 0, 0);
        exp_ev(t + 33, 2, 0, 1, 0, 0);
        exp_ev(t + 41, 1, 0, 1, 0, 0);
        exp_ev(t + 49, 0, 0, 0, 1, 0);
        exp_ev(t + 65, 0, 0, 0, 0, 0);
        pulse(4'b1001);
        check("t4_pending_both", 32'(pending), 32'h9);
        wait_until(t + 8);
        check("t4_pending_low", 32'(pending), 32'h1);
        wait_drain(120);
        check("t4_pending_end", 32'(pending), 32'd0);

        // 5: reset while travelling between floors 1 and 2
        do_reset();
        s = cyc + 1;
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 8, 1, 1, 0, 0, 0);
        pulse(4'b1000);
        wait_until(s + 11);
        check("t5_floor", 32'(cur_floor), 32'd1);
        check("t5_events", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        do_reset();

        // 6: estop held for 3 cycles during the first hop
        do_reset();
        s = cyc + 1;
`ifdef ELEVATOR_ESTOP_EN
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 3, 0, 0, 0, 0, 1);
        exp_ev(s + 6, 0, 1, 0, 0, 0);
        exp_ev(s + 12, 1, 1, 0, 0, 0);
        exp_ev(s + 20, 2, 1, 0, 0, 0);
        exp_ev(s + 28, 3, 0, 0, 1, 0);
        exp_ev(s + 44, 3, 0, 0, 0, 0);
`else
        exp_ev(s, 0, 1, 0, 0, 0);
        exp_ev(s + 8, 1, 1, 0, 0, 0);
        exp_ev(s + 16, 2, 1, 0, 0, 0);
        exp_ev(s + 24, 3, 0, 0, 1, 0);
        exp_ev(s + 40, 3, 0, 0, 0, 0);
`endif
        pulse(4'b1000);
        wait_until(s + 2);
        estop = 1'b1;
        wait_until(s + 4);
`ifdef ELEVATOR_ESTOP_EN
        check("t6_halted", 32'(halted), 32'd1);
        check("t6_up_off", 32'(moving_up), 32'd0);
        check("t6_floor", 32'(cur_floor), 32'd0);
        check("t6_pending", 32'(pending), 32'h8);
`else
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_up_on", 32'(moving_up), 32'd1);
`endif
        wait_until(s + 5);
        estop = 1'b0;
        wait_drain(100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
